// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding, default word width and mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFd   = 2'd1,
    StHrx  = 2'd2,
    StHtx  = 2'd3
  } spi_state_e;

  localparam int unsigned WordWDefault = 8;

  localparam logic SpiModeFull = 1'b0;
  localparam logic SpiModeHalf = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall detection on the synchronized value.
module spi_sync #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
      prev_q <= RstVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with full/half duplex operation, sampled on an oversampling system clock.
// Optional sticky overrun flag built only when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned WORD_W = WordWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  input  logic              SPIMode,
  input  logic [WORD_W-1:0] TxData,
  input  logic              TxLoad,
  output logic              MISO,
  output logic              MISOEn,
  output logic [WORD_W-1:0] RxData,
  output logic              RxValid,
  output logic              TxReady,
  output logic              Busy,
  output logic              Overrun
);

  localparam int unsigned CntW = $clog2(WORD_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync #(.RstVal(1'b0)) u_sync_sclk (
    .clk_i(clk), .rst_i(reset), .d_i(SCLK), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync #(.RstVal(1'b1)) u_sync_ss (
    .clk_i(clk), .rst_i(reset), .d_i(SS), .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  spi_sync #(.RstVal(1'b0)) u_sync_mosi (
    .clk_i(clk), .rst_i(reset), .d_i(MOSI), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, ss_s, mosi_rise, mosi_fall};

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WORD_W-2:0] rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ready_q, tx_ready_d;
  logic              reload_q, reload_d;
  logic              copy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = tx_ready_q;
    reload_d   = reload_q;
    copy       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d    = (SPIMode == SpiModeHalf) ? StHrx : StFd;
          cnt_d      = '0;
          rx_shift_d = '0;
          reload_d   = 1'b0;
          copy       = 1'b1;
        end
      end
      StFd, StHrx, StHtx: begin
        if (ss_rise) begin
          // Partial word is dropped; RxData keeps the last complete word.
          state_d  = StIdle;
          cnt_d    = '0;
          reload_d = 1'b0;
        end else begin
          if (sclk_rise) begin
            if (state_q != StHtx) rx_shift_d = {rx_shift_q[WORD_W-3:0], mosi_s};
            if (cnt_q == CntW'(WORD_W - 1)) begin
              cnt_d    = '0;
              reload_d = 1'b1;
              if (state_q != StHtx) begin
                rx_data_d  = {rx_shift_q, mosi_s};
                rx_valid_d = 1'b1;
              end
              if (state_q == StHrx) state_d = StHtx;
              if (state_q == StHtx) state_d = StHrx;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          // TX shifter only moves while MISO is driven; a pending reload waits for that.
          if (sclk_fall && (state_q == StFd || state_q == StHtx)) begin
            if (reload_q) begin
              copy     = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (copy) begin
      tx_shift_d = tx_ready_q ? '0 : hold_q;
      tx_ready_d = 1'b1;
    end
    // A load coinciding with the copy stays held for the next word.
    if (TxLoad) begin
      hold_d     = TxData;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      reload_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      reload_q   <= reload_d;
    end
  end

  assign MISOEn  = (state_q == StFd) || (state_q == StHtx);
  assign MISO    = MISOEn & tx_shift_q[WORD_W-1];
  assign RxData  = rx_data_q;
  assign RxValid = rx_valid_q;
  assign TxReady = tx_ready_q;
  assign Busy    = |cnt_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic unack_q, unack_d, overrun_q, overrun_d;

  always_comb begin
    unack_d   = unack_q;
    overrun_d = overrun_q;
    if (TxLoad) unack_d = 1'b0;
    if (rx_valid_d) begin
      if (unack_q && !TxLoad) overrun_d = 1'b1;
      unack_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unack_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      unack_q   <= unack_d;
      overrun_q <= overrun_d;
    end
  end

  assign Overrun = overrun_q;
`else
  assign Overrun = 1'b0;
`endif

endmodule
